// File: rtl/spi_sram_master.sv
// SPI mode-0 master issuing one 23LC-style SRAM read (0x03) or write (0x02) frame per
// host request: 8-bit command, 24-bit address and one data byte, MSB first.
`timescale 1ns/1ps
module spi_sram_master #(
  parameter int CLK_DIV = 2,
  parameter int CS_IDLE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wr,
  input  logic [23:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        cs_n,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso
);
  localparam int HW = $clog2(CLK_DIV + 1);
  localparam int GW = $clog2(CS_IDLE + 1);
  localparam logic [HW-1:0] HALF_RELOAD = HW'(CLK_DIV - 1);
  localparam logic [GW-1:0] GAP_RELOAD  = GW'(CS_IDLE);
  localparam logic [GW-1:0] GAP_LAST    = GW'(1);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_t;

  state_t          r_state;
  logic [39:0]     r_sr;
  logic [5:0]      r_bitcnt;
  logic [HW-1:0]   r_half;
  logic [GW-1:0]   r_gap;
  logic [7:0]      r_rd_sr;
  logic            r_wr;
  logic            r_cs_n;
  logic            r_sclk;
  logic            r_mosi;
  logic            r_rsp_valid;
  logic [7:0]      r_rsp_rdata;

  logic [7:0]      w_cmd;
  logic            w_half_done;

  assign w_cmd       = req_wr ? 8'h02 : 8'h03;
  assign w_half_done = (r_half == '0);
  // NOTE: req_ready is a pure decode of the state register, not a separate flop.
  assign req_ready   = (r_state == S_IDLE);
  assign cs_n        = r_cs_n;
  assign sclk        = r_sclk;
  assign mosi        = r_mosi;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;

  // NOTE: every register uses <= so all branches see the values from before the edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_sr        <= '0;
      r_bitcnt    <= '0;
      r_half      <= '0;
      r_gap       <= '0;
      r_rd_sr     <= '0;
      r_wr        <= 1'b0;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b0;
      r_mosi      <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 8'h00;
    end else begin
      r_rsp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_sr     <= {w_cmd, req_addr, req_wr ? req_wdata : 8'h00};
            r_bitcnt <= 6'd39;
            r_wr     <= req_wr;
            r_cs_n   <= 1'b0;
            r_mosi   <= w_cmd[7];
            r_half   <= HALF_RELOAD;
            r_state  <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (w_half_done) begin
            r_sclk  <= 1'b1;
            r_rd_sr <= {r_rd_sr[6:0], miso};
            r_half  <= HALF_RELOAD;
            r_state <= S_HIGH;
          end else begin
            r_half <= r_half - 1'b1;
          end
        end
        S_HIGH: begin
          // Falling edge launches the next bit so it is stable at the following rise.
          if (w_half_done) begin
            r_sclk  <= 1'b0;
            r_sr    <= {r_sr[38:0], 1'b0};
            r_mosi  <= r_sr[38];
            r_half  <= HALF_RELOAD;
            r_state <= S_LOW;
          end else begin
            r_half <= r_half - 1'b1;
          end
        end
        S_LOW: begin
          if (w_half_done) begin
            if (r_bitcnt != 6'd0) begin
              r_bitcnt <= r_bitcnt - 6'd1;
              r_sclk   <= 1'b1;
              r_rd_sr  <= {r_rd_sr[6:0], miso};
              r_half   <= HALF_RELOAD;
              r_state  <= S_HIGH;
            end else begin
              r_cs_n  <= 1'b1;
              r_mosi  <= 1'b0;
              r_gap   <= GAP_RELOAD;
              r_state <= S_GAP;
            end
          end else begin
            r_half <= r_half - 1'b1;
          end
        end
        S_GAP: begin
          // The first GAP cycle is the only one where the counter still holds its reload.
          if (r_gap == GAP_RELOAD) begin
            r_rsp_valid <= 1'b1;
            if (!r_wr) r_rsp_rdata <= r_rd_sr;
          end
          if (r_gap == GAP_LAST) r_state <= S_IDLE;
          r_gap <= r_gap - 1'b1;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_sram_master.sv
// Directed bench for spi_sram_master: a table of SRAM transactions against a behavioural
// 23LC-style slave, plus hand-written sequences for back-to-back, CLK_DIV=1 and reset abort.
`timescale 1ns/1ps
module tb_spi_sram_master;
  localparam int CS_IDLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // CLK_DIV=2 instance, connected to the slave model
  logic        req_valid = 1'b0, req_wr = 1'b0;
  logic [23:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic        req_ready, rsp_valid, cs_n, sclk, mosi;
  logic [7:0]  rsp_rdata;
  logic        miso = 1'b0;

  // CLK_DIV=1 instance, write-only monitor
  logic        d1_req_valid = 1'b0, d1_req_wr = 1'b0;
  logic [23:0] d1_req_addr = '0;
  logic [7:0]  d1_req_wdata = '0;
  logic        d1_req_ready, d1_rsp_valid, d1_cs_n, d1_sclk, d1_mosi;
  logic [7:0]  d1_rsp_rdata;
  logic        d1_miso = 1'b0;

  spi_sram_master #(.CLK_DIV(2), .CS_IDLE(CS_IDLE)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .cs_n(cs_n), .sclk(sclk), .mosi(mosi), .miso(miso)
  );

  spi_sram_master #(.CLK_DIV(1), .CS_IDLE(CS_IDLE)) dut1 (
    .clk(clk), .rst(rst), .req_valid(d1_req_valid), .req_ready(d1_req_ready), .req_wr(d1_req_wr),
    .req_addr(d1_req_addr), .req_wdata(d1_req_wdata), .rsp_valid(d1_rsp_valid),
    .rsp_rdata(d1_rsp_rdata), .cs_n(d1_cs_n), .sclk(d1_sclk), .mosi(d1_mosi), .miso(d1_miso)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Slave model: samples mosi on sclk rise, drives miso after sclk fall.
  logic [7:0]  mem [logic [23:0]];
  logic [39:0] s_sh = '0, s_frame = '0;
  int          s_bits = 0, s_rises = 0;
  logic [7:0]  s_out = '0;
  logic        s_rd = 1'b0;

  always @(posedge sclk or posedge cs_n) begin
    if (cs_n) begin
      s_frame = s_sh;
      s_rises = s_bits;
      s_bits  = 0;
      s_sh    = '0;
    end else begin
      s_sh = {s_sh[38:0], mosi};
      s_bits++;
      if (s_bits == 40 && s_sh[39:32] == 8'h02) mem[s_sh[31:8]] = s_sh[7:0];
    end
  end

  always @(negedge sclk) begin
    if (!cs_n && s_bits == 32) begin
      s_rd  = (s_sh[31:24] == 8'h03);
      s_out = mem.exists(s_sh[23:0]) ? mem[s_sh[23:0]] : 8'h00;
    end
    if (!cs_n && s_bits >= 32 && s_bits < 40 && s_rd) begin
      miso  = s_out[7];
      s_out = {s_out[6:0], 1'b0};
    end else begin
      miso = 1'b0;
    end
  end

  logic [39:0] d1_sh = '0, d1_frame = '0;
  int          d1_bits = 0, d1_rises = 0;

  always @(posedge d1_sclk or posedge d1_cs_n) begin
    if (d1_cs_n) begin
      d1_frame = d1_sh;
      d1_rises = d1_bits;
      d1_bits  = 0;
      d1_sh    = '0;
    end else begin
      d1_sh = {d1_sh[38:0], d1_mosi};
      d1_bits++;
    end
  end

  int rv_count = 0;
  always @(posedge clk) if (rsp_valid) rv_count++;

  typedef struct {
    logic        wr;
    logic [23:0] addr;
    logic [7:0]  wdata;
    logic [39:0] frame;
    logic [7:0]  rdata;
  } vec_t;

  vec_t vecs [7];

  // Issues one request on the CLK_DIV=2 instance; the request inputs are scrambled right
  // after the accept edge so any late sampling shows up in the frame.
  task automatic run_txn(input logic wr, input logic [23:0] addr, input logic [7:0] wdata,
                         output int lat, output int csl, output logic [7:0] rdata,
                         output logic pulse_after);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_wr = wr; req_addr = addr; req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 1000) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wr = ~wr; req_addr = ~addr; req_wdata = ~wdata;
    lat = 0; csl = 0;
    while (!rsp_valid && lat < 2000) begin
      if (!cs_n) csl++;
      @(negedge clk);
      lat++;
    end
    rdata = rsp_rdata;
    @(negedge clk);
    pulse_after = rsp_valid;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, csl, acc, idx1, idx2, pulses, hi_run, hi_gap, tog, rv_before, n;
    logic [7:0] rd;
    logic pa, prev_sclk, seen_low;

    vecs[0] = '{1'b1, 24'h123456, 8'hA5, 40'h02123456A5, 8'h00};
    vecs[1] = '{1'b0, 24'h000010, 8'h77, 40'h0300001000, 8'h3C};
    vecs[2] = '{1'b1, 24'h000020, 8'h5A, 40'h020000205A, 8'h3C};
    vecs[3] = '{1'b0, 24'h000020, 8'h00, 40'h0300002000, 8'h5A};
    vecs[4] = '{1'b1, 24'hFFFFFF, 8'h00, 40'h02FFFFFF00, 8'h5A};
    vecs[5] = '{1'b0, 24'hFFFFFF, 8'h00, 40'h03FFFFFF00, 8'h00};
    vecs[6] = '{1'b0, 24'h123456, 8'h00, 40'h0312345600, 8'hA5};
    mem[24'h000010] = 8'h3C;

    #2 rst = 1'b1;
    #20;
    check("reset cs_n", cs_n, 1'b1);
    check("reset sclk", sclk, 1'b0);
    check("reset mosi", mosi, 1'b0);
    check("reset rsp_valid", rsp_valid, 1'b0);
    check("reset rsp_rdata", rsp_rdata, 8'h00);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    check("req_ready after reset", req_ready, 1'b1);

    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, lat, csl, rd, pa);
      check($sformatf("v%0d frame", i), s_frame, vecs[i].frame);
      check($sformatf("v%0d rises", i), s_rises, 40);
      check($sformatf("v%0d cs_n low cycles", i), csl, 162);
      check($sformatf("v%0d accept to rsp_valid", i), lat, 163);
      check($sformatf("v%0d rsp_rdata", i), rd, vecs[i].rdata);
      check($sformatf("v%0d rsp_valid one cycle", i), pa, 1'b0);
      repeat (6) @(negedge clk);
    end

    // Back-to-back reads with req_valid held high.
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 24'h000010;
    acc = 0; idx1 = -1; idx2 = -1; pulses = 0; hi_run = 0; hi_gap = -1; seen_low = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (rsp_valid) pulses++;
      if (!cs_n) begin
        if (seen_low && hi_run > 0 && hi_gap < 0) hi_gap = hi_run;
        seen_low = 1'b1; hi_run = 0;
      end else if (seen_low) begin
        hi_run++;
      end
      if (req_ready && req_valid) begin
        acc++;
        if (acc == 1) idx1 = i;
        if (acc == 2) idx2 = i;
      end
      @(negedge clk);
      if (acc == 2) req_valid = 1'b0;
    end
    check("b2b accepts", acc, 2);
    check("b2b ready spacing", idx2 - idx1, 167);
    // GAP lasts CS_IDLE cycles and the IDLE accept cycle adds one more with cs_n high.
    check("b2b cs_n high between frames", hi_gap, CS_IDLE + 1);
    check("b2b rsp_valid pulses", pulses, 2);
    check("b2b rsp_rdata", rsp_rdata, 8'h3C);

    // CLK_DIV=1 write to the top address.
    @(negedge clk);
    d1_req_valid = 1'b1; d1_req_wr = 1'b1; d1_req_addr = 24'hFFFFFF; d1_req_wdata = 8'hFF;
    n = 0;
    while (!d1_req_ready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    @(negedge clk);
    d1_req_valid = 1'b0; d1_req_addr = '0; d1_req_wdata = '0;
    csl = 0; tog = 0; prev_sclk = d1_sclk; n = 0;
    while (!d1_cs_n && n < 500) begin
      csl++;
      if (n > 0 && d1_sclk != prev_sclk) tog++;
      prev_sclk = d1_sclk;
      @(negedge clk);
      n++;
    end
    check("div1 cs_n low cycles", csl, 81);
    check("div1 sclk toggles", tog, 80);
    check("div1 rises", d1_rises, 40);
    check("div1 frame", d1_frame, 40'h02FFFFFFFF);
    n = 0;
    while (!d1_rsp_valid && n < 20) begin @(negedge clk); n++; end
    check("div1 rsp_valid after cs_n", n, 1);
    repeat (8) @(negedge clk);

    // Reset in the middle of a read.
    check("rdata before abort", rsp_rdata, 8'h3C);
    @(negedge clk);
    req_valid = 1'b1; req_wr = 1'b0; req_addr = 24'h000010;
    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (s_bits < 20 && n < 1000) begin @(negedge clk); n++; end
    check("abort reached 20th rise", s_bits, 20);
    rv_before = rv_count;
    rst = 1'b1;
    #1;
    check("abort cs_n", cs_n, 1'b1);
    check("abort sclk", sclk, 1'b0);
    check("abort mosi", mosi, 1'b0);
    check("abort rsp_rdata", rsp_rdata, 8'h00);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("abort req_ready after release", req_ready, 1'b1);
    repeat (200) @(negedge clk);
    check("abort no rsp_valid", rv_count - rv_before, 0);
    check("abort cs_n stays high", cs_n, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
